// File: rtl/frame_packer_pkg.sv
// Shared types for the pixel-to-framebuffer-word packer: accumulator state,
// the packed framebuffer word carried through the output FIFO, and row geometry.
package frame_packer_pkg;

    localparam int DEFAULT_H_PIXELS = 320;
    localparam int WORDS_PER_ROW    = DEFAULT_H_PIXELS / 8;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } packer_state_t;

    typedef struct packed {
        logic [13:0]  addr;
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
    } fb_word_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous first-word-fall-through FIFO of framebuffer words; head visible the cycle after push.
// A push while full is ignored unless a pop happens the same cycle, which frees the slot.
module word_fifo
    import frame_packer_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_vld,
    input  fb_word_t push_dat,
    input  logic     pop,
    output fb_word_t head_dat,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    fb_word_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push_vld && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        head_dat = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/frame_packer.sv
// Packs RGB565 pixels into 8-lane framebuffer words; a completed word is visible one cycle later.
// No input backpressure: words are dropped (sticky overflow) when the FIFO is full. FRAME_PACKER_DOUBLE_BUFFER_EN drives addr[13].
module frame_packer
    import frame_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int H_PIXELS   = DEFAULT_H_PIXELS,
    parameter int V_PIXELS   = 180
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [8:0]   pixel_h,
    input  logic [7:0]   pixel_v,
    input  logic         pixel_valid,
    input  logic         pixel_last,
    input  logic [15:0]  pixel_data,
    output logic [13:0]  word_addr,
    output logic [127:0] word_data,
    output logic [15:0]  word_strb,
    output logic         word_last,
    output logic         word_valid,
    input  logic         word_ready,
    output logic         frame_done,
    output logic         overflow,
    output logic         bad_coord
);
    localparam int ROW_WORDS = H_PIXELS / 8;

    packer_state_t state_q, state_d;
    fb_word_t      acc_q, acc_d, hold_q, hold_d;
    fb_word_t      new_word, merged, p1, push_dat, head_dat;
    logic          hold_vld_q, hold_vld_d;
    logic          ovf_q, ovf_d, bad_q, bad_d, done_q, done_d;
    logic          p1_vld, p2_vld, push_vld, fifo_full, fifo_empty;
    logic          in_range, pix_vld, completes;
    logic [12:0]   pix_addr;
    logic [2:0]    lane;
    logic [127:0]  lane_data, lane_mask;
    logic [15:0]   lane_strb;
`ifdef FRAME_PACKER_DOUBLE_BUFFER_EN
    logic          fsel_q, fsel_d;
`endif

    always_comb begin
        lane      = pixel_h[2:0];
        pix_addr  = {5'd0, pixel_v} * 13'(ROW_WORDS) + {7'd0, pixel_h[8:3]};
        in_range  = (32'(pixel_h) < H_PIXELS) && (32'(pixel_v) < V_PIXELS);
        pix_vld   = pixel_valid && in_range;
        completes = (lane == 3'd7) || pixel_last;
        lane_data = {112'd0, pixel_data} << {lane, 4'd0};
        lane_mask = {112'd0, 16'hFFFF} << {lane, 4'd0};
        lane_strb = 16'b11 << {lane, 1'b0};

        new_word.addr = {1'b0, pix_addr};
        new_word.data = lane_data;
        new_word.strb = lane_strb;
        new_word.last = pixel_last;

        merged      = acc_q;
        merged.data = (acc_q.data & ~lane_mask) | lane_data;
        merged.strb = acc_q.strb | lane_strb;
        merged.last = pixel_last;

        state_d = state_q;
        acc_d   = acc_q;
        p1      = acc_q;
        p1_vld  = 1'b0;
        p2_vld  = 1'b0;

        // p1 is the word pushed first; p2 only arises when a partial word is flushed
        // and the incoming pixel completes a word in the same cycle.
        if (pix_vld) begin
            if (state_q == ACCUM && pix_addr != acc_q.addr[12:0]) begin
                p1_vld = 1'b1;
                if (completes) begin
                    p2_vld  = 1'b1;
                    state_d = EMPTY;
                end else begin
                    acc_d = new_word;
                end
            end else begin
                if (completes) begin
                    p1      = (state_q == ACCUM) ? merged : new_word;
                    p1_vld  = 1'b1;
                    state_d = EMPTY;
                end else begin
                    acc_d   = (state_q == ACCUM) ? merged : new_word;
                    state_d = ACCUM;
                end
            end
        end

        // A valid hold word implies the packer ended the previous cycle in EMPTY,
        // so at most one new word can compete with it.
        if (hold_vld_q) begin
            push_vld   = 1'b1;
            push_dat   = hold_q;
            hold_d     = p1;
            hold_vld_d = p1_vld;
        end else begin
            push_vld   = p1_vld;
            push_dat   = p1;
            hold_d     = new_word;
            hold_vld_d = p2_vld;
        end

`ifdef FRAME_PACKER_DOUBLE_BUFFER_EN
        push_dat.addr[13] = fsel_q;
        fsel_d = (push_vld && push_dat.last) ? ~fsel_q : fsel_q;
`else
        push_dat.addr[13] = 1'b0;
`endif

        ovf_d  = ovf_q | (push_vld && fifo_full && !word_ready);
        bad_d  = bad_q | (pixel_valid && !in_range);
        done_d = word_valid && word_ready && word_last;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            acc_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            bad_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            ovf_q      <= ovf_d;
            bad_q      <= bad_d;
            done_q     <= done_d;
        end
    end

`ifdef FRAME_PACKER_DOUBLE_BUFFER_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsel_q <= 1'b0;
        end else begin
            fsel_q <= fsel_d;
        end
    end
`endif

    word_fifo #(.DEPTH(FIFO_DEPTH)) u_word_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop      (word_ready),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Outputs read zero whenever the FIFO is empty so no stale entry is ever visible.
    always_comb begin
        word_valid = !fifo_empty;
        word_addr  = word_valid ? head_dat.addr : '0;
        word_data  = word_valid ? head_dat.data : '0;
        word_strb  = word_valid ? head_dat.strb : '0;
        word_last  = word_valid && head_dat.last;
        frame_done = done_q;
        overflow   = ovf_q;
        bad_coord  = bad_q;
    end

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer: expected words are queued as pixels are driven
// and compared when the DUT hands each word over.
module tb_frame_packer;
    import frame_packer_pkg::*;

    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [8:0]   pixel_h = '0;
    logic [7:0]   pixel_v = '0;
    logic         pixel_valid = 1'b0;
    logic         pixel_last = 1'b0;
    logic [15:0]  pixel_data = '0;
    logic [13:0]  word_addr;
    logic [127:0] word_data;
    logic [15:0]  word_strb;
    logic         word_last;
    logic         word_valid;
    logic         word_ready = 1'b1;
    logic         frame_done;
    logic         overflow;
    logic         bad_coord;

    fb_word_t exp_q [$];
    int       checks = 0;
    int       errors = 0;
    int       fd_count = 0;
    logic     hs_last_prev = 1'b0;
`ifdef FRAME_PACKER_DOUBLE_BUFFER_EN
    logic     exp_fsel = 1'b0;
`endif

    frame_packer #(.FIFO_DEPTH(DEPTH), .H_PIXELS(320), .V_PIXELS(180)) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_h     (pixel_h),
        .pixel_v     (pixel_v),
        .pixel_valid (pixel_valid),
        .pixel_last  (pixel_last),
        .pixel_data  (pixel_data),
        .word_addr   (word_addr),
        .word_data   (word_data),
        .word_strb   (word_strb),
        .word_last   (word_last),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .bad_coord   (bad_coord)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input int a, input logic [127:0] d, input logic [15:0] s, input logic l);
        fb_word_t w;
`ifdef FRAME_PACKER_DOUBLE_BUFFER_EN
        w.addr = {exp_fsel, 13'(a)};
        if (l) exp_fsel = ~exp_fsel;
`else
        w.addr = {1'b0, 13'(a)};
`endif
        w.data = d;
        w.strb = s;
        w.last = l;
        exp_q.push_back(w);
    endtask

    task automatic pix(input int h, input int v, input logic [15:0] d, input logic last);
        pixel_h     = 9'(h);
        pixel_v     = 8'(v);
        pixel_data  = d;
        pixel_last  = last;
        pixel_valid = 1'b1;
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_word_valid"}, word_valid, 1'b0);
        chk({pfx, "_word_last"},  word_last,  1'b0);
        chk({pfx, "_frame_done"}, frame_done, 1'b0);
        chk({pfx, "_overflow"},   overflow,   1'b0);
        chk({pfx, "_bad_coord"},  bad_coord,  1'b0);
        chk({pfx, "_word_addr"},  word_addr,  14'd0);
        chk({pfx, "_word_data"},  word_data,  128'd0);
        chk({pfx, "_word_strb"},  word_strb,  16'd0);
    endtask

    function automatic logic [15:0] pval(input int h, input int v);
        return 16'(v * 320 + h) ^ 16'h5A3C;
    endfunction

    // Output monitor: pops the scoreboard on each handshake and checks the done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            hs_last_prev = 1'b0;
        end else begin
            chk("frame_done", frame_done, hs_last_prev);
            if (frame_done) fd_count++;
            hs_last_prev = 1'b0;
            if (word_valid && word_ready) begin
                chk("scoreboard_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    fb_word_t w;
                    w = exp_q.pop_front();
                    chk("word_addr", word_addr, w.addr);
                    chk("word_data", word_data, w.data);
                    chk("word_strb", word_strb, w.strb);
                    chk("word_last", word_last, w.last);
                    hs_last_prev = w.last;
                end
            end
        end
    end

    initial begin
        logic [127:0] wd;
        int           wcount;

        idle(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        idle(1);

        // Full in-order frame with the downstream always ready.
        wd = '0;
        for (int v = 0; v < 180; v++) begin
            for (int h = 0; h < 320; h++) begin
                wd[16*(h%8) +: 16] = pval(h, v);
                if (h % 8 == 7) expect_word(v * 40 + h / 8, wd, 16'hFFFF, (v == 179 && h == 319));
                pix(h, v, pval(h, v), (v == 179 && h == 319));
            end
        end
        idle(4);
        chk("raster_drained", exp_q.size(), 0);
        chk("raster_frame_done_count", fd_count, 1);

        // Jump to a different word flushes a partial word.
        expect_word(0, 128'(16'h1111) << 80, 16'h0C00, 1'b0);
        pix(5, 0, 16'h1111, 1'b0);
        pix(17, 0, 16'h2222, 1'b0);
        expect_word(2, (128'(16'h2222) << 16) | (128'(16'h3333) << 112), 16'hC00C, 1'b0);
        pix(23, 0, 16'h3333, 1'b0);

        // Repeated lane overwrites data, strobe stays set.
        pix(83, 0, 16'hAAAA, 1'b0);
        pix(83, 0, 16'hBBBB, 1'b0);
        expect_word(10, (128'(16'hBBBB) << 48) | (128'(16'hCCCC) << 112), 16'hC0C0, 1'b0);
        pix(87, 0, 16'hCCCC, 1'b0);

        // Out-of-range pixel is ignored; then flush+complete uses the hold register.
        chk("bad_coord_before", bad_coord, 1'b0);
        pix(0, 1, 16'hD00D, 1'b0);
        pix(320, 0, 16'hEEEE, 1'b0);
        chk("bad_coord_h320", bad_coord, 1'b1);
        expect_word(40, 128'(16'hD00D), 16'h0003, 1'b0);
        expect_word(41, 128'(16'hE00E) << 112, 16'hC000, 1'b0);
        pix(15, 1, 16'hE00E, 1'b0);
        expect_word(42, 128'(16'hF00F) << 112, 16'hC000, 1'b0);
        pix(23, 1, 16'hF00F, 1'b0);
        idle(4);
        chk("directed_drained", exp_q.size(), 0);
        chk("overflow_clear", overflow, 1'b0);

        // Stall downstream: DEPTH words fit, the next one is dropped.
        word_ready = 1'b0;
        wd = '0;
        wcount = 0;
        for (int i = 0; i < 8 * (DEPTH + 1); i++) begin
            int h, v;
            h = (640 + i) % 320;
            v = (640 + i) / 320;
            wd[16*(h%8) +: 16] = pval(h, v);
            if (h % 8 == 7) begin
                if (wcount < DEPTH) expect_word(v * 40 + h / 8, wd, 16'hFFFF, 1'b0);
                wcount++;
            end
            pix(h, v, pval(h, v), 1'b0);
            if (i == 8 * DEPTH - 1) begin
                chk("full_no_overflow_yet", overflow, 1'b0);
                chk("full_head_addr", word_addr, exp_q[0].addr);
            end
        end
        chk("overflow_set", overflow, 1'b1);
        idle(3);
        chk("stall_head_valid", word_valid, 1'b1);
        chk("stall_head_addr", word_addr, exp_q[0].addr);
        chk("stall_head_data", word_data, exp_q[0].data);
        word_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) idle(1);
        idle(2);
        chk("overflow_drained", exp_q.size(), 0);
        chk("overflow_sticky", overflow, 1'b1);
        chk("no_frame_done_after_overflow", fd_count, 1);

        // Reset in the middle of a word discards the partial accumulator.
        pix(0, 5, 16'h1234, 1'b0);
        rst = 1'b0;
        idle(1);
        check_reset_outputs("midreset");
        rst = 1'b1;
`ifdef FRAME_PACKER_DOUBLE_BUFFER_EN
        exp_fsel = 1'b0;
`endif
        wd = '0;
        for (int h = 8; h < 16; h++) begin
            wd[16*(h%8) +: 16] = pval(h, 5);
            if (h == 15) expect_word(201, wd, 16'hFFFF, 1'b0);
            pix(h, 5, pval(h, 5), 1'b0);
        end
        chk("latency_word_valid", word_valid, 1'b1);
        chk("latency_word_addr_low", word_addr[12:0], 13'd201);
        idle(4);
        chk("final_drained", exp_q.size(), 0);
        chk("no_stale_word", word_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
